// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, one-outstanding instruction-memory
// handshake, and the IF/ID register presented to decode. A single-entry skid
// buffer catches a response that lands while decode is stalled.
module fetch_unit #(
  parameter int PC_W   = 9,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PcSel,
  input  logic [31:0]       BrPC,
  input  logic              Stall,
  input  logic              Halt,
  output logic              Inst_Req,
  output logic [PC_W-1:0]   Inst_Addr,
  input  logic              Inst_Ack,
  input  logic [INST_W-1:0] Inst_Rdata,
  output logic [PC_W-1:0]   IF_PC,
  output logic [INST_W-1:0] IF_Inst,
  output logic              IF_Valid,
  output logic              Halted
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Redirect targets are word aligned; only the PC-width slice is kept.
  function automatic logic [PC_W-1:0] align_target(input logic [31:0] target);
    return {target[PC_W-1:2], 2'b00};
  endfunction

  // Sequential fetch address, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] cur);
    return cur + PC_W'(4);
  endfunction

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc, pc_nxt;
  logic                squash, squash_nxt;
  logic                halt_pend, halt_pend_nxt;

  logic [PC_W-1:0]     req_pc_p0;
  logic                buf_valid_p0;
  logic [PC_W-1:0]     buf_pc_p0;
  logic [INST_W-1:0]   buf_inst_p0;

  logic                vld_p1;
  logic [PC_W-1:0]     if_pc_p1;
  logic [INST_W-1:0]   if_inst_p1;

  logic                issue;
  logic                ack_take;
  logic [PC_W-1:0]     br_target;

  assign br_target = align_target(BrPC);
  assign issue     = (state == S_RUN) && !Stall && !PcSel && !Halt;
  // A response is kept only if no redirect has overtaken it.
  assign ack_take  = (state == S_WAIT) && Inst_Ack && !squash && !PcSel;

  assign Inst_Req  = issue;
  assign Inst_Addr = pc;
  assign IF_PC     = if_pc_p1;
  assign IF_Inst   = if_inst_p1;
  assign IF_Valid  = vld_p1;
  assign Halted    = (state == S_HALT);

  // Fetch control state: FSM, PC, squash and deferred-halt flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      pc        <= '0;
      squash    <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      squash    <= squash_nxt;
      halt_pend <= halt_pend_nxt;
    end
  end

  // Next-state logic: request issue, redirects, halt handling.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    squash_nxt    = squash;
    halt_pend_nxt = halt_pend;
    case (state)
      S_RUN: begin
        if (PcSel) begin
          pc_nxt = br_target;
        end else if (Halt) begin
          state_nxt = S_HALT;
        end else if (!Stall) begin
          pc_nxt    = next_seq_pc(pc);
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (PcSel) begin
          pc_nxt     = br_target;
          squash_nxt = 1'b1;
        end
        if (Halt) begin
          halt_pend_nxt = 1'b1;
        end
        // The response closes the transaction whether it is kept or dropped.
        if (Inst_Ack) begin
          squash_nxt    = 1'b0;
          halt_pend_nxt = 1'b0;
          state_nxt     = (halt_pend || Halt) ? S_HALT : S_RUN;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  // ---- stage p0: outstanding request address and skid-buffer payload ----
  // Payload registers need no reset; they are only read behind a valid flag.
  always_ff @(posedge clk) begin
    if (issue) begin
      req_pc_p0 <= pc;
    end
    if (ack_take && Stall) begin
      buf_pc_p0   <= req_pc_p0;
      buf_inst_p0 <= Inst_Rdata;
    end
  end

  // ---- stage p1: IF/ID register and skid-buffer occupancy ----
  // Priority: flush, stall hold, skid drain, fresh response, bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1       <= 1'b0;
      if_pc_p1     <= '0;
      if_inst_p1   <= '0;
      buf_valid_p0 <= 1'b0;
    end else if (PcSel) begin
      vld_p1       <= 1'b0;
      buf_valid_p0 <= 1'b0;
    end else if (Stall) begin
      if (ack_take) begin
        buf_valid_p0 <= 1'b1;
      end
    end else if (buf_valid_p0) begin
      vld_p1       <= 1'b1;
      if_pc_p1     <= buf_pc_p0;
      if_inst_p1   <= buf_inst_p0;
      buf_valid_p0 <= 1'b0;
    end else if (ack_take) begin
      vld_p1     <= 1'b1;
      if_pc_p1   <= req_pc_p0;
      if_inst_p1 <= Inst_Rdata;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  // The skid entry drains before any new request can be outstanding.
  skid_empty_in_wait: assert property (
    @(posedge clk) disable iff (!reset) !(buf_valid_p0 && (state == S_WAIT))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors covering
// sequential fetch, redirect squash, stall with skid buffer and PC wrap,
// followed by hand-written halt and mid-transaction reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PcSel = 1'b0;
  logic [31:0] BrPC = '0;
  logic        Stall = 1'b0;
  logic        Halt = 1'b0;
  logic        Inst_Req;
  logic [8:0]  Inst_Addr;
  logic        Inst_Ack = 1'b0;
  logic [31:0] Inst_Rdata = '0;
  logic [8:0]  IF_PC;
  logic [31:0] IF_Inst;
  logic        IF_Valid;
  logic        Halted;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_W(9), .INST_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .PcSel     (PcSel),
    .BrPC      (BrPC),
    .Stall     (Stall),
    .Halt      (Halt),
    .Inst_Req  (Inst_Req),
    .Inst_Addr (Inst_Addr),
    .Inst_Ack  (Inst_Ack),
    .Inst_Rdata(Inst_Rdata),
    .IF_PC     (IF_PC),
    .IF_Inst   (IF_Inst),
    .IF_Valid  (IF_Valid),
    .Halted    (Halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pcsel;
    logic [31:0] brpc;
    logic        stall;
    logic        halt;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [8:0]  addr;
    logic        ifv;
    logic        chk_if;
    logic [8:0]  ifpc;
    logic [31:0] ifinst;
    logic        halted;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic pcsel, input logic [31:0] brpc, input logic stall,
    input logic halt, input logic ack, input logic [31:0] rdata,
    input logic req, input logic [8:0] addr, input logic ifv,
    input logic chk_if, input logic [8:0] ifpc, input logic [31:0] ifinst,
    input logic halted);
    vec_t v;
    v.pcsel = pcsel; v.brpc = brpc; v.stall = stall; v.halt = halt;
    v.ack = ack; v.rdata = rdata; v.req = req; v.addr = addr; v.ifv = ifv;
    v.chk_if = chk_if; v.ifpc = ifpc; v.ifinst = ifinst; v.halted = halted;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".IF_Valid"}, 32'(IF_Valid), 32'd0);
    chk({tag, ".IF_PC"},    32'(IF_PC),    32'd0);
    chk({tag, ".IF_Inst"},  IF_Inst,       32'd0);
    chk({tag, ".Halted"},   32'(Halted),   32'd0);
  endtask

  // Called at posedge+2: drive one cycle of inputs, check at posedge+4,
  // then advance to the next posedge+2.
  task automatic apply(input vec_t v, input string tag);
    PcSel      = v.pcsel;
    BrPC       = v.brpc;
    Stall      = v.stall;
    Halt       = v.halt;
    Inst_Ack   = v.ack;
    Inst_Rdata = v.rdata;
    #2;
    chk({tag, ".Inst_Req"}, 32'(Inst_Req), 32'(v.req));
    if (v.req) chk({tag, ".Inst_Addr"}, 32'(Inst_Addr), 32'(v.addr));
    chk({tag, ".IF_Valid"}, 32'(IF_Valid), 32'(v.ifv));
    if (v.ifv || v.chk_if) begin
      chk({tag, ".IF_PC"},   32'(IF_PC), 32'(v.ifpc));
      chk({tag, ".IF_Inst"}, IF_Inst,    v.ifinst);
    end
    chk({tag, ".Halted"}, 32'(Halted), 32'(v.halted));
    @(posedge clk);
    #2;
  endtask

  initial begin
    // pcsel brpc stall halt ack rdata | req addr ifv chk_if ifpc ifinst halted
    // Sequential fetch, 1-cycle memory latency.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hA000,   0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h004, 1, 1, 9'h000, 32'hA000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hA004,   0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h008, 1, 1, 9'h004, 32'hA004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hA008,   0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h00C, 1, 1, 9'h008, 32'hA008, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hA00C,   0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h010, 1, 1, 9'h00C, 32'hA00C, 0));
    // Redirect while 0x010 is outstanding; its late response is dropped.
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0,     0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hDEAD,   0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h040, 0, 1, 9'h00C, 32'hA00C, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hA040,   0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h044, 1, 1, 9'h040, 32'hA040, 0));
    // Stall for three cycles around the response; skid buffer delivers once.
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,          0, 0,      0, 1, 9'h040, 32'hA040, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h1234,   0, 0,      0, 1, 9'h040, 32'hA040, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,          0, 0,      0, 1, 9'h040, 32'hA040, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h048, 0, 1, 9'h040, 32'hA040, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hA048,   0, 0,      1, 1, 9'h044, 32'h1234, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h04C, 1, 1, 9'h048, 32'hA048, 0));
    // Redirect coinciding with the response; then PC wrap at 0x1FC.
    tbl.push_back(mk(1, 32'h1FC, 0, 0, 1, 32'hBAD, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h1FC, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hA1FC,   0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h000, 1, 1, 9'h1FC, 32'hA1FC, 0));
    // Out-of-range redirect target keeps only bits [8:2].
    tbl.push_back(mk(1, 32'hFFFF_FE42, 0, 0, 1, 32'hA000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h040, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hA040,   0, 0,      0, 0, 0, 0, 0));
    // Flush beats Stall on a valid IF/ID entry.
    tbl.push_back(mk(1, 32'h80, 1, 0, 0, 0,     0, 0,      1, 1, 9'h040, 32'hA040, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9'h080, 0, 0, 0, 0, 0));

    @(posedge clk);
    #2;
    chk_reset_vals("reset");
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Halt while 0x080 is outstanding: deliver it, then stay halted.
    apply(mk(0, 0, 0, 1, 0, 0,          0, 0, 0, 0, 0, 0, 0), "halt_wait");
    apply(mk(0, 0, 0, 1, 1, 32'hA080,   0, 0, 0, 0, 0, 0, 0), "halt_ack");
    apply(mk(0, 0, 0, 1, 0, 0,          0, 0, 1, 1, 9'h080, 32'hA080, 1), "halt_deliver");
    for (int i = 0; i < 20; i++) begin
      logic ps;
      ps = i[0];
      apply(mk(ps, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 9'h080, 32'hA080, 1),
            $sformatf("halt_idle%0d", i));
    end

    // Reset out of HALT.
    reset = 1'b0;
    #2;
    chk_reset_vals("rst_from_halt");
    @(posedge clk);
    #2;
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0,        1, 9'h000, 0, 1, 9'h000, 32'h0, 0), "r6_a");
    apply(mk(0, 0, 0, 0, 1, 32'hA000, 0, 0,      0, 0, 0, 0, 0), "r6_b");
    apply(mk(0, 0, 0, 0, 0, 0,        1, 9'h004, 1, 1, 9'h000, 32'hA000, 0), "r6_c");

    // Asynchronous reset while 0x004 is outstanding.
    reset = 1'b0;
    #2;
    chk_reset_vals("rst_mid_wait");
    @(posedge clk);
    #2;
    reset = 1'b1;
    // Late response for the aborted request must be ignored.
    apply(mk(0, 0, 0, 0, 1, 32'hBEEF, 1, 9'h000, 0, 1, 9'h000, 32'h0, 0), "r6_late_ack");
    apply(mk(0, 0, 0, 0, 0, 0,        0, 0,      0, 1, 9'h000, 32'h0, 0), "r6_e");
    apply(mk(0, 0, 0, 0, 1, 32'hA000, 0, 0,      0, 0, 0, 0, 0), "r6_f");
    apply(mk(1, 32'h20, 1, 0, 0, 0,   0, 0,      1, 1, 9'h000, 32'hA000, 0), "r6_flush_stall");
    apply(mk(0, 0, 0, 0, 0, 0,        1, 9'h020, 0, 0, 0, 0, 0), "r6_after_flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
